// File: rtl/mystic_main_mem_tx.sv
// UART 8N1 memory-dump transmitter: reads a byte range through a byte read port and serialises it on uart_tx_o.
// Optional MYSTIC_MEM_TX_CHECKSUM_EN appends one frame carrying the mod-256 sum of all transmitted data bytes.
module mystic_main_mem_tx #(
  parameter int ADDR_W = 18,
  parameter int BAUD_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BAUD_W-1:0] baud_div_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] byte_cnt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_din_i,
  output logic              uart_tx_o
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [BAUD_W-1:0] div_q, div_d;
  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic              bit_end;
  logic              fetch_mem;

`ifdef MYSTIC_MEM_TX_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  // Set while the extra checksum frame is in flight; its FETCH/LATCH are a silent gap.
  logic       csum_q, csum_d;
`endif

  assign bit_end = (cnt_q == '0);

  // NOTE: every combinational output gets a default before the case so no latches are inferred.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef MYSTIC_MEM_TX_CHECKSUM_EN
    sum_d   = sum_q;
    csum_d  = csum_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d = start_addr_i;
          rem_d  = byte_cnt_i;
          div_d  = (baud_div_i < BAUD_W'(2)) ? BAUD_W'(2) : baud_div_i;
`ifdef MYSTIC_MEM_TX_CHECKSUM_EN
          sum_d  = '0;
          csum_d = 1'b0;
`endif
          state_d = (byte_cnt_i == '0) ? DONE : FETCH;
        end
      end

      FETCH: state_d = LATCH;

      LATCH: begin
`ifdef MYSTIC_MEM_TX_CHECKSUM_EN
        if (csum_q) begin
          shift_d = sum_q;
        end else begin
          shift_d = mem_din_i;
          sum_d   = sum_q + mem_din_i;
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - ADDR_W'(1);
        end
`else
        shift_d = mem_din_i;
        addr_d  = addr_q + ADDR_W'(1);
        rem_d   = rem_q - ADDR_W'(1);
`endif
        cnt_d   = div_q - BAUD_W'(1);
        state_d = START;
      end

      START: begin
        if (bit_end) begin
          cnt_d   = div_q - BAUD_W'(1);
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d   = div_q - BAUD_W'(1);
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          if (rem_q != '0) state_d = FETCH;
`ifdef MYSTIC_MEM_TX_CHECKSUM_EN
          else if (!csum_q) begin
            csum_d  = 1'b1;
            state_d = FETCH;
          end
`endif
          else state_d = DONE;
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they line up with the state they belong to.
`ifdef MYSTIC_MEM_TX_CHECKSUM_EN
    fetch_mem = (state_d == FETCH) && !csum_d;
`else
    fetch_mem = (state_d == FETCH);
`endif
    rd_d    = fetch_mem;
    maddr_d = fetch_mem ? addr_d : maddr_q;
    busy_d  = (state_d != IDLE) && (state_d != DONE);
    done_d  = (state_d == DONE);
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the datapath is reset too so nothing starts as X.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      div_q   <= BAUD_W'(2);
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      maddr_q <= '0;
`ifdef MYSTIC_MEM_TX_CHECKSUM_EN
      sum_q   <= '0;
      csum_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      maddr_q <= maddr_d;
`ifdef MYSTIC_MEM_TX_CHECKSUM_EN
      sum_q   <= sum_d;
      csum_q  <= csum_d;
`endif
    end
  end

  assign uart_tx_o  = tx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign mem_rd_o   = rd_q;
  assign mem_addr_o = maddr_q;

endmodule
